// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_pkg
//  Purpose  : Shared encodings for the memory stage: store/load op codes,
//             FSM states, W-register bubble values and an op-decode helper.
//  Revision : 1.0
// ============================================================================
package mem_stage_pkg;

  // mem_storeM encoding
  localparam logic [1:0] c_ST_NONE = 2'd0;
  localparam logic [1:0] c_ST_SB   = 2'd1;
  localparam logic [1:0] c_ST_SH   = 2'd2;
  localparam logic [1:0] c_ST_SW   = 2'd3;

  // mem_loadM encoding; codes 6 and 7 decode as "no load"
  localparam logic [2:0] c_LD_NONE = 3'd0;
  localparam logic [2:0] c_LD_LB   = 3'd1;
  localparam logic [2:0] c_LD_LH   = 3'd2;
  localparam logic [2:0] c_LD_LW   = 3'd3;
  localparam logic [2:0] c_LD_LBU  = 3'd4;
  localparam logic [2:0] c_LD_LHU  = 3'd5;

  // Bus transaction FSM
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Values loaded into W when M is stalled (pcW bubble is all-zero as well)
  localparam logic [31:0] c_BUBBLE_INST     = 32'h0000_0000;
  localparam logic [4:0]  c_BUBBLE_RD       = 5'd0;
  localparam logic [31:0] c_BUBBLE_RESULT   = 32'h0000_0000;
  localparam logic        c_BUBBLE_REGWRITE = 1'b0;
  localparam logic        c_BUBBLE_TRAP     = 1'b0;

  // True for the five real load encodings
  function automatic logic isLoadOp(input logic [2:0] ld);
    return (ld >= c_LD_LB) && (ld <= c_LD_LHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_if
//  Purpose  : Valid/ready data bus between the memory stage (master) and
//             the data memory (slave); load responses are one-cycle pulses.
//  Revision : 1.0
// ============================================================================
interface mem_stage_if;
  logic        dreq_valid;
  logic        dreq_ready;
  logic        dreq_we;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_be;
  logic [31:0] dreq_wdata;
  logic        drsp_valid;
  logic [31:0] drsp_rdata;

  modport master (
    output dreq_valid, dreq_we, dreq_addr, dreq_be, dreq_wdata,
    input  dreq_ready, drsp_valid, drsp_rdata
  );

  modport slave (
    input  dreq_valid, dreq_we, dreq_addr, dreq_be, dreq_wdata,
    output dreq_ready, drsp_valid, drsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_load_align
//  Purpose  : Selects the addressed byte/half lane of a load word and sign-
//             or zero-extends it to 32 bits. Purely combinational.
//  Revision : 1.0
// ============================================================================
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_memLoad,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection by byte offset, then extension by load type
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_off)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_data = i_rdata;
    case (i_memLoad)
      c_LD_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      c_LD_LH:  o_data = {{16{w_half[15]}}, w_half};
      c_LD_LBU: o_data = {24'h00_0000, w_byte};
      c_LD_LHU: o_data = {16'h0000, w_half};
      default:  o_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Memory pipeline stage. Issues loads/stores on a valid/ready
//             bus, aligns store data, extends load data, stalls upstream
//             while a transaction is outstanding and registers M->W.
//  Revision : 1.0
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int PC_W = 13,
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [PC_W-1:0] pcM,
  input  logic [31:0]     instM,
  input  logic [4:0]      rdM,
  input  logic [XLEN-1:0] resultM,
  input  logic [XLEN-1:0] reg_data2M,
  input  logic [1:0]      mem_storeM,
  input  logic [2:0]      mem_loadM,
  input  logic            reg_writeM,
  output logic            stallM,
  mem_stage_if.master     dbus,
  output logic [PC_W-1:0] pcW,
  output logic [31:0]     instW,
  output logic [4:0]      rdW,
  output logic [XLEN-1:0] resultW,
  output logic            reg_writeW,
  output logic            trapW
);

  state_t      r_state;
  logic [1:0]  w_off;
  logic        w_isStore;
  logic        w_isLoad;
  logic        w_memop;
  logic        w_misaligned;
  logic        w_reqValid;
  logic        w_respDone;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_loadData;

  // Op decode and alignment check; a store overrides any load encoding
  always_comb begin
    w_off        = resultM[1:0];
    w_isStore    = (mem_storeM != c_ST_NONE);
    w_isLoad     = !w_isStore && isLoadOp(mem_loadM);
    w_memop      = w_isStore || w_isLoad;
    w_misaligned = 1'b0;
    if (w_isStore) begin
      case (mem_storeM)
        c_ST_SH: w_misaligned = w_off[0];
        c_ST_SW: w_misaligned = (w_off != 2'd0);
        default: w_misaligned = 1'b0;
      endcase
    end else if (w_isLoad) begin
      case (mem_loadM)
        c_LD_LH, c_LD_LHU: w_misaligned = w_off[0];
        c_LD_LW:           w_misaligned = (w_off != 2'd0);
        default:           w_misaligned = 1'b0;
      endcase
    end
  end

  // Store lane enables and replicated write data; loads enable all lanes
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = reg_data2M;
    case (mem_storeM)
      c_ST_SB: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{reg_data2M[7:0]}};
      end
      c_ST_SH: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{reg_data2M[15:0]}};
      end
      default: ;
    endcase
  end

  // Request/stall generation; stores retire on accept, loads wait for data
  always_comb begin
    w_reqValid = 1'b0;
    w_respDone = 1'b0;
    stallM     = 1'b0;
    case (r_state)
      IDLE: begin
        w_reqValid = w_memop && !w_misaligned;
        stallM     = w_reqValid && !(w_isStore && dbus.dreq_ready);
      end
      RESP: begin
        w_respDone = dbus.drsp_valid;
        stallM     = !dbus.drsp_valid;
      end
      default: ;
    endcase
  end

  assign dbus.dreq_valid = w_reqValid;
  assign dbus.dreq_we    = w_isStore;
  assign dbus.dreq_addr  = {resultM[31:2], 2'b00};
  assign dbus.dreq_be    = w_be;
  assign dbus.dreq_wdata = w_wdata;

  mem_stage_load_align u_loadAlign (
    .i_rdata   (dbus.drsp_rdata),
    .i_off     (w_off),
    .i_memLoad (mem_loadM),
    .o_data    (w_loadData)
  );

  // Transaction FSM: an accepted load waits in RESP for its response pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_reqValid && w_isLoad && dbus.dreq_ready) r_state <= RESP;
        RESP:    if (dbus.drsp_valid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // M->W register: bubble while M is stalled, otherwise capture M
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pcW        <= '0;
      instW      <= '0;
      rdW        <= '0;
      resultW    <= '0;
      reg_writeW <= 1'b0;
      trapW      <= 1'b0;
    end else if (stallM) begin
      pcW        <= '0;
      instW      <= c_BUBBLE_INST;
      rdW        <= c_BUBBLE_RD;
      resultW    <= c_BUBBLE_RESULT;
      reg_writeW <= c_BUBBLE_REGWRITE;
      trapW      <= c_BUBBLE_TRAP;
    end else begin
      pcW        <= pcM;
      instW      <= instM;
      rdW        <= rdM;
      resultW    <= w_respDone ? w_loadData : resultM;
      reg_writeW <= reg_writeM && !w_isStore && !w_misaligned;
      trapW      <= w_memop && w_misaligned;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage: directed scenarios plus
//             randomized ops against a behavioural memory-stage model.
//  Revision : 1.0
// ============================================================================
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [12:0] pcM;
  logic [31:0] instM;
  logic [4:0]  rdM;
  logic [31:0] resultM;
  logic [31:0] reg_data2M;
  logic [1:0]  mem_storeM;
  logic [2:0]  mem_loadM;
  logic        reg_writeM;
  logic        stallM;
  logic [12:0] pcW;
  logic [31:0] instW;
  logic [4:0]  rdW;
  logic [31:0] resultW;
  logic        reg_writeW;
  logic        trapW;

  int checks = 0;
  int errors = 0;

  // Observations gathered by the bus responder for one M-stage op
  int          obs_stall, obs_valid, obs_bubbleBad;
  bit          obs_unstable, obs_timeout;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  mem_stage_if bus ();

  mem_stage #(.PC_W(13), .XLEN(32)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .pcM        (pcM),
    .instM      (instM),
    .rdM        (rdM),
    .resultM    (resultM),
    .reg_data2M (reg_data2M),
    .mem_storeM (mem_storeM),
    .mem_loadM  (mem_loadM),
    .reg_writeM (reg_writeM),
    .stallM     (stallM),
    .dbus       (bus),
    .pcW        (pcW),
    .instW      (instW),
    .rdW        (rdW),
    .resultW    (resultW),
    .reg_writeW (reg_writeW),
    .trapW      (trapW)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [1:0] st, input logic [2:0] ld);
    if (st == 2'd1) return 1;
    if (st == 2'd2) return 2;
    if (st == 2'd3) return 4;
    if (ld == 3'd1 || ld == 3'd4) return 1;
    if (ld == 3'd2 || ld == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] rs2, input int size);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++)
      r = r | (((rs2 >> (8 * (i % size))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] m_loadval(input logic [2:0] ld, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    int unsigned w = rdata >> (8 * (addr % 4));
    int v;
    case (ld)
      3'd1: begin v = int'(w % 256);   if (v >= 128)   v = v - 256;   end
      3'd4: v = int'(w % 256);
      3'd2: begin v = int'(w % 65536); if (v >= 32768) v = v - 65536; end
      3'd5: v = int'(w % 65536);
      default: v = int'(rdata);
    endcase
    return 32'(v);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_nop();
    pcM = '0; instM = '0; rdM = '0; resultM = '0; reg_data2M = '0;
    mem_storeM = 2'd0; mem_loadM = 3'd0; reg_writeM = 1'b0;
  endtask

  // Acts as the memory for the op currently on the M inputs: raises ready after
  // readyDelay cycles, answers a load respDelay cycles after accept, injects
  // stray responses while no load is outstanding. Returns right after the edge
  // at which W captured the op.
  task automatic run_op(input int readyDelay, input int respDelay, input logic [31:0] rdata);
    int  cyc = 0;
    int  acceptCyc = 0;
    bit  accepted = 0;
    bit  done = 0;
    bit  firstReq = 1;
    obs_stall = 0; obs_valid = 0; obs_bubbleBad = 0; obs_unstable = 0; obs_timeout = 0;
    obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0;
    while (!done) begin
      bus.dreq_ready = (cyc >= readyDelay);
      if (accepted) begin
        bus.drsp_valid = (cyc == acceptCyc + respDelay);
        bus.drsp_rdata = bus.drsp_valid ? rdata : $urandom;
      end else begin
        bus.drsp_valid = 1'($urandom_range(0, 1));
        bus.drsp_rdata = $urandom;
      end
      @(negedge CLK);
      if (bus.dreq_valid) begin
        obs_valid++;
        if (firstReq) begin
          obs_addr = bus.dreq_addr; obs_be = bus.dreq_be;
          obs_wdata = bus.dreq_wdata; obs_we = bus.dreq_we;
          firstReq = 0;
        end else if (bus.dreq_addr !== obs_addr || bus.dreq_be !== obs_be ||
                     bus.dreq_wdata !== obs_wdata || bus.dreq_we !== obs_we) begin
          obs_unstable = 1;
        end
        if (bus.dreq_ready && !accepted) begin
          accepted = 1;
          acceptCyc = cyc;
        end
      end
      if (stallM) obs_stall++;
      done = (stallM === 1'b0);
      @(posedge CLK); #1;
      if (!done && (pcW !== 0 || instW !== 0 || rdW !== 0 || resultW !== 0 ||
                    reg_writeW !== 0 || trapW !== 0))
        obs_bubbleBad++;
      cyc++;
      if (cyc > 40) begin obs_timeout = 1; done = 1; end
    end
    bus.dreq_ready = 1'b0;
    bus.drsp_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    set_nop();
    bus.dreq_ready = 1'b0; bus.drsp_valid = 1'b0; bus.drsp_rdata = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({pcW, instW, rdW, resultW, reg_writeW, trapW} !== '0)
      $display("FAIL reset_w: got pc=%h inst=%h rd=%h res=%h rw=%b trap=%b required all 0",
               pcW, instW, rdW, resultW, reg_writeW, trapW);
    checks++;
    if (stallM !== 1'b0 || bus.dreq_valid !== 1'b0)
      $display("FAIL reset_bus: got stall=%b valid=%b required 0 0", stallM, bus.dreq_valid);
    if (stallM !== 1'b0 || bus.dreq_valid !== 1'b0) errors++;
    if ({pcW, instW, rdW, resultW, reg_writeW, trapW} !== '0) errors++;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    // fill W with non-zero values, then check reset clears it without a clock edge
    pcM = 13'h1AB; instM = 32'h0000_0013; rdM = 5'd9; resultM = 32'hCAFE_0001; reg_writeM = 1'b1;
    run_op(0, 1, 32'h0);
    #1 RST_N = 1'b0;
    #1;
    checks++;
    if ({pcW, instW, rdW, resultW, reg_writeW, trapW} !== '0) begin
      errors++;
      $display("FAIL reset_async: got pc=%h inst=%h res=%h rw=%b required all 0",
               pcW, instW, resultW, reg_writeW);
    end
    RST_N = 1'b1;
    set_nop();
    @(posedge CLK); #1;
  endtask

  task automatic test_alu();
    set_nop();
    pcM = 13'h040; instM = 32'h1234_0033; rdM = 5'd5; resultM = 32'h0000_1234; reg_writeM = 1'b1;
    run_op(0, 1, 32'h0);
    checks++;
    if (resultW !== 32'h1234 || rdW !== 5'd5 || reg_writeW !== 1'b1) begin
      errors++;
      $display("FAIL alu_w: got res=%h rd=%0d rw=%b required 00001234 5 1", resultW, rdW, reg_writeW);
    end
    checks++;
    if (obs_stall !== 0 || obs_valid !== 0) begin
      errors++;
      $display("FAIL alu_stall: got stall=%0d valid=%0d required 0 0", obs_stall, obs_valid);
    end
  endtask

  task automatic test_store_sb();
    set_nop();
    pcM = 13'h044; instM = 32'h00A1_0123; rdM = 5'd3; resultM = 32'h0000_0102;
    reg_data2M = 32'hAABB_CCDD; mem_storeM = 2'd1; reg_writeM = 1'b1;
    run_op(0, 1, 32'h0);
    checks++;
    if (obs_be !== 4'b0100 || obs_wdata !== 32'hDDDD_DDDD || obs_addr !== 32'h100 || obs_we !== 1'b1) begin
      errors++;
      $display("FAIL sb_req: got be=%b wdata=%h addr=%h we=%b required 0100 DDDDDDDD 00000100 1",
               obs_be, obs_wdata, obs_addr, obs_we);
    end
    checks++;
    if (obs_stall !== 0 || reg_writeW !== 1'b0 || obs_valid !== 1) begin
      errors++;
      $display("FAIL sb_w: got stall=%0d rw=%b valid=%0d required 0 0 1", obs_stall, reg_writeW, obs_valid);
    end
  endtask

  task automatic test_load_byte();
    set_nop();
    pcM = 13'h048; instM = 32'h0000_0003; rdM = 5'd7; resultM = 32'h0000_0203;
    mem_loadM = 3'd1; reg_writeM = 1'b1;
    run_op(0, 1, 32'h80FF_0000);
    checks++;
    if (obs_stall !== 1 || resultW !== 32'hFFFF_FF80 || reg_writeW !== 1'b1) begin
      errors++;
      $display("FAIL lb: got stall=%0d res=%h rw=%b required 1 FFFFFF80 1", obs_stall, resultW, reg_writeW);
    end
    checks++;
    if (obs_be !== 4'hF || obs_we !== 1'b0 || obs_addr !== 32'h200) begin
      errors++;
      $display("FAIL lb_req: got be=%b we=%b addr=%h required 1111 0 00000200", obs_be, obs_we, obs_addr);
    end
    mem_loadM = 3'd4;
    run_op(0, 1, 32'h80FF_0000);
    checks++;
    if (obs_stall !== 1 || resultW !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu: got stall=%0d res=%h required 1 00000080", obs_stall, resultW);
    end
  endtask

  task automatic test_lw_wait();
    logic [31:0] rdata = $urandom;
    set_nop();
    pcM = 13'h04C; instM = 32'h0000_2003; rdM = 5'd11; resultM = 32'h0000_0400;
    mem_loadM = 3'd3; reg_writeM = 1'b1;
    run_op(3, 2, rdata);
    checks++;
    if (obs_stall !== 5 || obs_valid !== 4) begin
      errors++;
      $display("FAIL lw_wait_cycles: got stall=%0d valid=%0d required 5 4", obs_stall, obs_valid);
    end
    checks++;
    if (obs_bubbleBad !== 0 || obs_unstable !== 0 || obs_timeout !== 0) begin
      errors++;
      $display("FAIL lw_wait_hold: got bubbleBad=%0d unstable=%0d timeout=%0d required 0 0 0",
               obs_bubbleBad, obs_unstable, obs_timeout);
    end
    checks++;
    if (resultW !== rdata || rdW !== 5'd11 || reg_writeW !== 1'b1) begin
      errors++;
      $display("FAIL lw_wait_data: got res=%h rd=%0d rw=%b required %h 11 1", resultW, rdW, reg_writeW, rdata);
    end
  endtask

  task automatic test_misaligned();
    set_nop();
    pcM = 13'h050; instM = 32'h0000_1003; rdM = 5'd12; resultM = 32'h0000_0301;
    mem_loadM = 3'd2; reg_writeM = 1'b1;
    run_op(0, 1, 32'h0);
    checks++;
    if (obs_valid !== 0 || obs_stall !== 0) begin
      errors++;
      $display("FAIL mis_bus: got valid=%0d stall=%0d required 0 0", obs_valid, obs_stall);
    end
    checks++;
    if (trapW !== 1'b1 || reg_writeW !== 1'b0 || pcW !== 13'h050 || rdW !== 5'd12 || instW !== 32'h1003) begin
      errors++;
      $display("FAIL mis_w: got trap=%b rw=%b pc=%h rd=%0d inst=%h required 1 0 050 12 00001003",
               trapW, reg_writeW, pcW, rdW, instW);
    end
  endtask

  task automatic test_reset_in_resp();
    set_nop();
    pcM = 13'h054; instM = 32'h0000_2083; rdM = 5'd13; resultM = 32'h0000_0500;
    mem_loadM = 3'd3; reg_writeM = 1'b1;
    bus.dreq_ready = 1'b1; bus.drsp_valid = 1'b0;
    @(negedge CLK);
    @(posedge CLK); #1;
    bus.dreq_ready = 1'b0;
    #1 RST_N = 1'b0;
    #2 RST_N = 1'b1;
    bus.drsp_valid = 1'b1; bus.drsp_rdata = 32'h1357_9BDF;
    @(negedge CLK);
    checks++;
    if (stallM !== 1'b1 || bus.dreq_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_resp_state: got stall=%b valid=%b required 1 1 (idle, request pending)",
               stallM, bus.dreq_valid);
    end
    @(posedge CLK); #1;
    checks++;
    if ({pcW, instW, rdW, resultW, reg_writeW, trapW} !== '0) begin
      errors++;
      $display("FAIL rst_resp_w: got pc=%h inst=%h res=%h rw=%b required all 0", pcW, instW, resultW, reg_writeW);
    end
    bus.drsp_valid = 1'b0;
    set_nop();
    @(posedge CLK); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int          kind, rdy, rsp, size;
      logic [31:0] rdata, expRes, expWdata;
      logic [3:0]  expBe;
      bit          isStore, isLoad, mis, go, expRw;
      int          expStall, expValid;
      kind = $urandom_range(0, 2);
      rdy = $urandom_range(0, 3);
      rsp = $urandom_range(1, 3);
      rdata = $urandom;
      pcM = 13'($urandom); instM = $urandom; rdM = 5'($urandom);
      resultM = $urandom; reg_data2M = $urandom; reg_writeM = 1'($urandom_range(0, 1));
      case (kind)
        0: begin
          mem_storeM = 2'd0;
          mem_loadM = 3'($urandom_range(0, 2));
          if (mem_loadM != 0) mem_loadM = mem_loadM + 3'd5;
        end
        1: begin mem_storeM = 2'($urandom_range(1, 3)); mem_loadM = 3'($urandom); end
        default: begin mem_storeM = 2'd0; mem_loadM = 3'($urandom_range(1, 5)); end
      endcase
      isStore = (mem_storeM != 0);
      isLoad = !isStore && mem_loadM >= 1 && mem_loadM <= 5;
      size = m_size(isStore ? mem_storeM : 2'd0, mem_loadM);
      mis = (isStore || isLoad) && (resultM % size != 0);
      go = (isStore || isLoad) && !mis;
      expStall = go ? (isStore ? rdy : rdy + rsp) : 0;
      expValid = go ? rdy + 1 : 0;
      expBe = isStore ? 4'(((1 << size) - 1) << (resultM % 4)) : 4'hF;
      expWdata = m_wdata(reg_data2M, size);
      expRes = (isLoad && go) ? m_loadval(mem_loadM, resultM, rdata) : resultM;
      expRw = reg_writeM && !isStore && !mis;

      run_op(rdy, rsp, rdata);

      checks++;
      if (obs_stall !== expStall || obs_valid !== expValid || obs_timeout !== 0) begin
        errors++;
        $display("FAIL rnd%0d_timing: got stall=%0d valid=%0d timeout=%0d required %0d %0d 0 (st=%0d ld=%0d addr=%h)",
                 n, obs_stall, obs_valid, obs_timeout, expStall, expValid, mem_storeM, mem_loadM, resultM);
      end
      checks++;
      if (obs_bubbleBad !== 0 || obs_unstable !== 0) begin
        errors++;
        $display("FAIL rnd%0d_hold: got bubbleBad=%0d unstable=%0d required 0 0", n, obs_bubbleBad, obs_unstable);
      end
      if (go) begin
        checks++;
        if (obs_addr !== {resultM[31:2], 2'b00} || obs_be !== expBe || obs_we !== isStore) begin
          errors++;
          $display("FAIL rnd%0d_req: got addr=%h be=%b we=%b required %h %b %b",
                   n, obs_addr, obs_be, obs_we, {resultM[31:2], 2'b00}, expBe, isStore);
        end
        if (isStore) begin
          checks++;
          if (obs_wdata !== expWdata) begin
            errors++;
            $display("FAIL rnd%0d_wdata: got %h required %h", n, obs_wdata, expWdata);
          end
        end
      end
      checks++;
      if (resultW !== expRes || reg_writeW !== expRw || trapW !== mis) begin
        errors++;
        $display("FAIL rnd%0d_w: got res=%h rw=%b trap=%b required %h %b %b (st=%0d ld=%0d addr=%h)",
                 n, resultW, reg_writeW, trapW, expRes, expRw, mis, mem_storeM, mem_loadM, resultM);
      end
      checks++;
      if (pcW !== pcM || instW !== instM || rdW !== rdM) begin
        errors++;
        $display("FAIL rnd%0d_ids: got pc=%h inst=%h rd=%0d required %h %h %0d", n, pcW, instW, rdW, pcM, instM, rdM);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_sb();
    test_load_byte();
    test_lw_wait();
    test_misaligned();
    test_reset_in_resp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
